// File: rtl/prog_loader_rom.sv
// prog_loader_rom: 16x8 CPU program memory, reloadable over an 8N1 UART
// while the CPU is held in reset. Optional frame checksum: PROG_CHECKSUM_EN.
//
// Ports:
//   clk       in   system clock
//   reset     in   async active-low reset
//   adr       in   [3:0] CPU fetch address
//   dout      out  [7:0] instruction byte (0x00 while not in RUN)
//   uart_rx   in   serial input, idle high, asynchronous
//   cpu_reset out  active-low CPU reset (low while loading / in error)
//   loading   out  frame reception in progress
//   load_err  out  framing error, timeout or checksum mismatch
module prog_loader_rom #(
   parameter int unsigned  CLKS_PER_BIT = 234,
   parameter int unsigned  TIMEOUT_CYC  = 2_700_000,
   parameter logic [127:0] INIT_IMAGE   = '0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] adr,
   output logic [7:0] dout,
   input  logic       uart_rx,
   output logic       cpu_reset,
   output logic       loading,
   output logic       load_err
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int GW = $clog2(TIMEOUT_CYC + 2);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [GW-1:0] TO   = GW'(TIMEOUT_CYC);
   localparam logic [7:0]    SYNC = 8'hA5;

   typedef enum logic [1:0] {
      RX_IDLE, RX_START, RX_DATA, RX_STOP
   } rx_st_e;

`ifdef PROG_CHECKSUM_EN
   typedef enum logic [1:0] {
      S_RUN = 2'd0, S_LOAD = 2'd1, S_CHECK = 2'd2, S_ERR = 2'd3
   } st_e;
`else
   typedef enum logic [1:0] {
      S_RUN = 2'd0, S_LOAD = 2'd1, S_ERR = 2'd3
   } st_e;
`endif

   // ---------------- UART receiver ----------------
   logic          rx_s1_q, rx_s2_q, rx_prev_q;
   rx_st_e        rx_st_q, rx_st_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_sh_q, rx_sh_d;
   logic          rx_valid, rx_ferr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
         rx_st_q   <= RX_IDLE;
         rx_cnt_q  <= '0;
         rx_bit_q  <= '0;
         rx_sh_q   <= '0;
      end else begin
         rx_s1_q   <= uart_rx;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
         rx_st_q   <= rx_st_d;
         rx_cnt_q  <= rx_cnt_d;
         rx_bit_q  <= rx_bit_d;
         rx_sh_q   <= rx_sh_d;
      end
   end

   always_comb begin
      rx_st_d  = rx_st_q;
      rx_cnt_d = rx_cnt_q + 1'b1;
      rx_bit_d = rx_bit_q;
      rx_sh_d  = rx_sh_q;
      rx_valid = 1'b0;
      rx_ferr  = 1'b0;
      case (rx_st_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_s2_q) rx_st_d = RX_START;
         end
         RX_START: begin
            // mid start bit: line back high means it was a glitch
            if (rx_cnt_q == HALF) begin
               rx_cnt_d = '0;
               rx_bit_d = '0;
               rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == FULL) begin
               rx_cnt_d = '0;
               rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
               rx_bit_d = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == FULL) begin
               rx_cnt_d = '0;
               rx_st_d  = RX_IDLE;
               rx_valid = rx_s2_q;
               rx_ferr  = !rx_s2_q;
            end
         end
         default: rx_st_d = RX_IDLE;
      endcase
   end

   // ---------------- loader FSM ----------------
   st_e           state_q, state_d;
   logic [3:0]    idx_q, idx_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          cr_q, ld_q, er_q;
   logic          mem_we;
   logic [7:0]    mem_q [16];
`ifdef PROG_CHECKSUM_EN
   logic [7:0]    sum_q, sum_d;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_RUN;
         idx_q   <= '0;
         gap_q   <= '0;
         cr_q    <= 1'b0;
         ld_q    <= 1'b0;
         er_q    <= 1'b0;
`ifdef PROG_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         cr_q    <= (state_d == S_RUN);
         ld_q    <= (state_d != S_RUN) && (state_d != S_ERR);
         er_q    <= (state_d == S_ERR);
`ifdef PROG_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      gap_d   = '0;
      mem_we  = 1'b0;
`ifdef PROG_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         S_RUN, S_ERR: begin
            if (rx_valid && rx_byte_is_sync(rx_sh_q)) begin
               state_d = S_LOAD;
               idx_d   = '0;
`ifdef PROG_CHECKSUM_EN
               sum_d   = '0;
`endif
            end
         end
         S_LOAD: begin
            gap_d = rx_valid ? '0 : gap_q + 1'b1;
            if (rx_ferr || gap_q > TO) begin
               state_d = S_ERR;
            end else if (rx_valid) begin
               mem_we = 1'b1;
               idx_d  = idx_q + 4'd1;
`ifdef PROG_CHECKSUM_EN
               sum_d  = sum_q + rx_sh_q;
               if (idx_q == 4'd15) state_d = S_CHECK;
`else
               if (idx_q == 4'd15) state_d = S_RUN;
`endif
            end
         end
`ifdef PROG_CHECKSUM_EN
         S_CHECK: begin
            gap_d = rx_valid ? '0 : gap_q + 1'b1;
            if (rx_ferr || gap_q > TO) begin
               state_d = S_ERR;
            end else if (rx_valid) begin
               state_d = (rx_sh_q == sum_q) ? S_RUN : S_ERR;
            end
         end
`endif
         default: state_d = S_RUN;
      endcase
   end

   function automatic logic rx_byte_is_sync(input logic [7:0] b);
      return b == SYNC;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 16; k++) mem_q[k] <= INIT_IMAGE[8*k +: 8];
      end else if (mem_we) begin
         mem_q[idx_q] <= rx_sh_q;
      end
   end

   // memory is hidden from the CPU until the image is complete
   assign dout      = (state_q == S_RUN) ? mem_q[adr] : 8'h00;
   assign cpu_reset = cr_q;
   assign loading   = ld_q;
   assign load_err  = er_q;

endmodule

// File: tb/tb_prog_loader_rom.sv
// tb_prog_loader_rom: directed UART frames with a queued scoreboard;
// a negedge monitor compares dout/cpu_reset/loading/load_err.
module tb_prog_loader_rom;

  localparam int CPB = 8;
  localparam logic [127:0] INIT = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] adr = '0;
  logic [7:0] dout;
  logic       uart_rx = 1'b1;
  logic       cpu_reset, loading, load_err;

  prog_loader_rom #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CYC (2000),
    .INIT_IMAGE  (INIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .adr      (adr),
    .dout     (dout),
    .uart_rx  (uart_rx),
    .cpu_reset(cpu_reset),
    .loading  (loading),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] tag;
    logic [7:0]  d;
    logic        cr;
    logic        ld;
    logic        er;
  } exp_t;

  exp_t sb[$];
  int   nchk  = 0;
  int   nfail = 0;

  logic [7:0] init_tab [16] = '{
    8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69, 8'h78,
    8'h87, 8'h96, 8'hA5, 8'hB4, 8'hC3, 8'hD2, 8'hE1, 8'hF0
  };

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        nchk++;
        if ({dout, cpu_reset, loading, load_err} !==
            {e.d, e.cr, e.ld, e.er}) begin
          nfail++;
          $display("FAIL chk%0d: got %h %b%b%b want %h %b%b%b",
                   e.tag, dout, cpu_reset, loading, load_err,
                   e.d, e.cr, e.ld, e.er);
        end
      end
    end
  end

  task automatic now_chk(input int tag, input logic [2:0] want);
    nchk++;
    if ({cpu_reset, loading, load_err} !== want) begin
      nfail++;
      $display("FAIL now%0d: got %b%b%b want %b",
               tag, cpu_reset, loading, load_err, want);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input int tag, input logic [3:0] a,
                     input logic [7:0] d, input logic cr,
                     input logic ld, input logic er);
    exp_t e;
    wait_cyc(1);
    adr = a;
    e.tag = 16'(tag);
    e.d   = d;
    e.cr  = cr;
    e.ld  = ld;
    e.er  = er;
    sb.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_cyc(CPB);
    end
    uart_rx = stop;
    wait_cyc(CPB);
    uart_rx = 1'b1;
    wait_cyc(2 * CPB);
  endtask

  initial begin : stim
    wait_cyc(1);
    chk(1, 4'd0, init_tab[0], 1'b0, 1'b0, 1'b0);
    wait_cyc(1);
    now_chk(100, 3'b000);
    reset = 1'b1;
    chk(2, 4'd0, init_tab[0], 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++)
      chk(10 + k, 4'(k), init_tab[k], 1'b1, 1'b0, 1'b0);

    send_byte(8'hA5, 1'b1);
    chk(30, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++) send_byte(8'(k), 1'b1);
`ifdef PROG_CHECKSUM_EN
    chk(31, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0);
`else
    chk(31, 4'd0, 8'h01, 1'b1, 1'b0, 1'b0);
`endif
    send_byte(8'h88, 1'b1);
    chk(32, 4'd3, 8'h04, 1'b1, 1'b0, 1'b0);
    chk(33, 4'd15, 8'h10, 1'b1, 1'b0, 1'b0);
    chk(34, 4'd0, 8'h01, 1'b1, 1'b0, 1'b0);

    send_byte(8'hA5, 1'b1);
    for (int k = 0; k < 16; k++) send_byte(8'h11, 1'b1);
    send_byte(8'h00, 1'b1);
`ifdef PROG_CHECKSUM_EN
    chk(40, 4'd2, 8'h00, 1'b0, 1'b0, 1'b1);
`else
    chk(40, 4'd2, 8'h11, 1'b1, 1'b0, 1'b0);
`endif
    send_byte(8'hA5, 1'b1);
    for (int k = 0; k < 16; k++)
      send_byte((k == 4) ? 8'hA5 : 8'(8'h20 + k), 1'b1);
`ifdef PROG_CHECKSUM_EN
    send_byte(8'hF9, 1'b1);
`endif
    chk(41, 4'd5, 8'h25, 1'b1, 1'b0, 1'b0);
    chk(42, 4'd15, 8'h2F, 1'b1, 1'b0, 1'b0);
    chk(43, 4'd4, 8'hA5, 1'b1, 1'b0, 1'b0);

    send_byte(8'hA5, 1'b1);
    for (int k = 0; k < 5; k++) send_byte(8'(8'h40 + k), 1'b1);
    chk(50, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0);
    wait_cyc(2500);
    chk(51, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    now_chk(101, 3'b001);
    send_byte(8'h33, 1'b1);
    send_byte(8'h33, 1'b1);
    chk(52, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1);

    send_byte(8'hA5, 1'b1);
    chk(60, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) send_byte(8'(8'h50 + k), 1'b1);
    reset = 1'b0;
    chk(61, 4'd0, init_tab[0], 1'b0, 1'b0, 1'b0);
    wait_cyc(1);
    reset = 1'b1;
    chk(62, 4'd7, init_tab[7], 1'b1, 1'b0, 1'b0);
    chk(63, 4'd15, init_tab[15], 1'b1, 1'b0, 1'b0);

    send_byte(8'h5A, 1'b1);
    chk(70, 4'd1, init_tab[1], 1'b1, 1'b0, 1'b0);
    uart_rx = 1'b0;
    wait_cyc(2);
    uart_rx = 1'b1;
    wait_cyc(10 * CPB);
    chk(71, 4'd10, init_tab[10], 1'b1, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0);
    chk(72, 4'd2, init_tab[2], 1'b1, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h44, 1'b0);
    chk(73, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1);

    wait_cyc(3);
    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end

endmodule
